// File: rtl/nor4_pkg.sv
// nor4_pkg: shared state encoding, coverage constant and reference NOR for the response checker
package nor4_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [15:0] FULL_COV = 16'hFFFF;
    function automatic logic nor4(input logic [3:0] index);
        return ~|index;
    endfunction
endpackage

// File: rtl/nor4_delay_line.sv
// nor4_delay_line: LATENCY-deep {valid, index} shift register with enable and synchronous clear
module nor4_delay_line #(
    parameter int LATENCY = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       in_valid,
    input  logic [3:0] in_index,
    output logic       out_valid,
    output logic [3:0] out_index
);
    // one stage always exists so a zero-latency build simply bypasses it
    localparam int D = (LATENCY == 0) ? 1 : LATENCY;
    logic [D-1:0][4:0] pipe;
    always_ff @(posedge clk) begin
        if (clr) begin
            pipe <= '0;
        end else if (en) begin
            pipe[0] <= {in_valid, in_index};
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign {out_valid, out_index} = (LATENCY == 0) ? {in_valid, in_index} : pipe[D-1];
endmodule

// File: rtl/nor4_response_checker.sv
// nor4_response_checker: compares a 4-input NOR gate output against its inputs and tracks coverage/errors
module nor4_response_checker
    import nor4_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      coverage,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);
    state_t state, state_nxt;
    logic [3:0] index, d_index;
    logic run, restart, d_valid, cmp, mis;
    logic [15:0] cov_nxt;
    assign index   = {a, b, c, d};
    assign run     = state == RUN;
    assign restart = start && !run;
    nor4_delay_line #(.LATENCY(LATENCY)) u_delay (
        .clk(clk),
        .clr(rst || restart),
        .en(sample_en),
        .in_valid(run),
        .in_index(index),
        .out_valid(d_valid),
        .out_index(d_index)
    );
    assign cmp     = run && sample_en && d_valid;
    assign mis     = cmp && (e != nor4(d_index));
    assign cov_nxt = coverage | (cmp ? (16'd1 << d_index) : 16'd0);
    always_comb begin
        state_nxt = state;
        if (restart)
            state_nxt = RUN;
        else if (run && (stop || (cmp && cov_nxt == FULL_COV)))
            state_nxt = DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            sample_cnt      <= '0;
            err_cnt         <= '0;
            coverage        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= state_nxt == RUN;
            done  <= state_nxt == DONE;
            if (restart) begin
                sample_cnt      <= '0;
                err_cnt         <= '0;
                coverage        <= '0;
                first_err_vec   <= '0;
                first_err_valid <= 1'b0;
            end else if (cmp) begin
                // counters stick at all-ones instead of wrapping
                sample_cnt <= sample_cnt + CNT_W'(sample_cnt != '1);
                coverage   <= cov_nxt;
                if (mis) begin
                    err_cnt <= err_cnt + CNT_W'(err_cnt != '1);
                    if (!first_err_valid) begin
                        first_err_vec   <= d_index;
                        first_err_valid <= 1'b1;
                    end
                end
            end
        end
    end
    assign pass = done && (err_cnt == '0) && (coverage == FULL_COV);
endmodule
